// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the in-order core datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_idx_t X0 = 5'd0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_scoreboard
//  Description : Busy-bit tracker for in-flight destination registers. Flags
//                RAW/WAW hazards for the instruction the decoder presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush_i,
    input  logic     wen_i,
    input  reg_idx_t waddr_i,
    input  logic     set_en_i,
    input  reg_idx_t set_addr_i,
    input  reg_idx_t rs1_i,
    input  reg_idx_t rs2_i,
    input  reg_idx_t rd_i,
    input  logic     rd_en_i,
    output logic     hazard_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wclr_mask;
    logic [NREGS-1:0] eff_busy;

    // A register being written back this cycle no longer blocks issue, so the
    // dependent instruction can go in the same cycle as the clearing write.
    always_comb begin
        wclr_mask = '0;
        if (wen_i) begin
            wclr_mask[waddr_i] = 1'b1;
        end
        eff_busy = busy_q & ~wclr_mask;
        hazard_o = eff_busy[rs1_i] | eff_busy[rs2_i] | (rd_en_i & eff_busy[rd_i]);
    end

    // Next busy state: flush clears everything; a new claim beats a same-cycle
    // retirement of the same register, since the newer writer is still pending.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (set_en_i && (set_addr_i == reg_idx_t'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wen_i && (waddr_i == reg_idx_t'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register; x0 is never busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule : register_file_scoreboard
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : Architectural register file with write-through bypass, a
//                registered operand pair for execute, and a hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wen,
    input  reg_idx_t        waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            decoder_valid,
    input  reg_idx_t        decoder_rs1,
    input  reg_idx_t        decoder_rs2,
    input  reg_idx_t        decoder_rd,
    input  logic            decoder_rd_en,
    output logic            regfile_ready,
    output logic            regfile_valid,
    output logic [XLEN-1:0] regfile_rs1_data,
    output logic [XLEN-1:0] regfile_rs2_data,
    input  logic            execute_ready,
    input  logic            flush
);

    logic [XLEN-1:0] regs_q [1:NREGS-1];

    logic            valid_q;
    logic            valid_d;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs1_d;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] rs2_d;

    logic            hazard;
    logic            slot_free;
    logic            accept;
    logic            sb_set_en;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    register_file_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .wen_i      (wen),
        .waddr_i    (waddr),
        .set_en_i   (sb_set_en),
        .set_addr_i (decoder_rd),
        .rs1_i      (decoder_rs1),
        .rs2_i      (decoder_rs2),
        .rd_i       (decoder_rd),
        .rd_en_i    (decoder_rd_en),
        .hazard_o   (hazard)
    );

    // Issue handshake; ready deliberately ignores decoder_valid.
    always_comb begin
        slot_free     = !valid_q || execute_ready;
        regfile_ready = !hazard && slot_free && !flush;
        accept        = decoder_valid && regfile_ready;
        sb_set_en     = accept && decoder_rd_en && (decoder_rd != X0);
    end

    // Operand read with same-cycle writeback forwarding; x0 reads as zero.
    always_comb begin
        rs1_fwd = '0;
        rs2_fwd = '0;
        if (decoder_rs1 != X0) begin
            rs1_fwd = (wen && (waddr == decoder_rs1)) ? wdata : regs_q[decoder_rs1];
        end
        if (decoder_rs2 != X0) begin
            rs2_fwd = (wen && (waddr == decoder_rs2)) ? wdata : regs_q[decoder_rs2];
        end
    end

    // Output stage next state: load on accept, drain when consumed, hold on stall.
    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            rs1_d   = rs1_fwd;
            rs2_d   = rs2_fwd;
        end else if (execute_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    // Architectural storage; writes commit even in a flush cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen && (waddr != X0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign regfile_valid    = valid_q;
    assign regfile_rs1_data = rs1_q;
    assign regfile_rs2_data = rs2_q;

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Directed self-checking bench for register_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        wen;
    reg_idx_t    waddr;
    logic [31:0] wdata;
    logic        decoder_valid;
    reg_idx_t    decoder_rs1;
    reg_idx_t    decoder_rs2;
    reg_idx_t    decoder_rd;
    logic        decoder_rd_en;
    logic        regfile_ready;
    logic        regfile_valid;
    logic [31:0] regfile_rs1_data;
    logic [31:0] regfile_rs2_data;
    logic        execute_ready;
    logic        flush;

    int checks = 0;
    int errors = 0;

    register_file dut (
        .clk              (clk),
        .reset            (reset),
        .wen              (wen),
        .waddr            (waddr),
        .wdata            (wdata),
        .decoder_valid    (decoder_valid),
        .decoder_rs1      (decoder_rs1),
        .decoder_rs2      (decoder_rs2),
        .decoder_rd       (decoder_rd),
        .decoder_rd_en    (decoder_rd_en),
        .regfile_ready    (regfile_ready),
        .regfile_valid    (regfile_valid),
        .regfile_rs1_data (regfile_rs1_data),
        .regfile_rs2_data (regfile_rs2_data),
        .execute_ready    (execute_ready),
        .flush            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 0; waddr = 0; wdata = 0;
        decoder_valid = 0; decoder_rs1 = 0; decoder_rs2 = 0;
        decoder_rd = 0; decoder_rd_en = 0; flush = 0; execute_ready = 1;
    endtask

    task automatic issue(input reg_idx_t rs1, input reg_idx_t rs2,
                         input reg_idx_t rd, input logic rd_en);
        decoder_valid = 1; decoder_rs1 = rs1; decoder_rs2 = rs2;
        decoder_rd = rd; decoder_rd_en = rd_en;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        #1;
        checks++;
        if (regfile_valid !== 1'b0 || regfile_rs1_data !== 32'h0 || regfile_rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b rs1=%h rs2=%h, expected 0/0/0",
                     regfile_valid, regfile_rs1_data, regfile_rs2_data);
        end
        checks++;
        if (regfile_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", regfile_ready);
        end
    endtask

    task automatic test_x0();
        issue(0, 0, 0, 0);
        wen = 1; waddr = 0; wdata = 32'hDEADBEEF;
        cyc();
        checks++;
        if (regfile_valid !== 1'b1 || regfile_rs1_data !== 32'h0 || regfile_rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_issue: valid=%b rs1=%h rs2=%h, expected 1/0/0",
                     regfile_valid, regfile_rs1_data, regfile_rs2_data);
        end
        wen = 0;
        issue(0, 0, 0, 0);
        cyc();
        checks++;
        if (regfile_rs1_data !== 32'h0) begin
            errors++;
            $display("FAIL x0_write_ignored: got %h expected 00000000", regfile_rs1_data);
        end
        idle();
        cyc();
        checks++;
        if (regfile_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid: got %b expected 0", regfile_valid);
        end
    endtask

    task automatic test_bypass();
        wen = 1; waddr = 5; wdata = 32'h12345678;
        issue(5, 6, 0, 0);
        #1;
        checks++;
        if (regfile_ready !== 1'b1) begin
            errors++;
            $display("FAIL bypass_ready: got %b expected 1", regfile_ready);
        end
        cyc();
        checks++;
        if (regfile_rs1_data !== 32'h12345678 || regfile_rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL bypass_data: rs1=%h rs2=%h, expected 12345678/00000000",
                     regfile_rs1_data, regfile_rs2_data);
        end
        wen = 0;
        issue(6, 5, 0, 0);
        cyc();
        checks++;
        if (regfile_rs1_data !== 32'h0 || regfile_rs2_data !== 32'h12345678) begin
            errors++;
            $display("FAIL storage_read: rs1=%h rs2=%h, expected 00000000/12345678",
                     regfile_rs1_data, regfile_rs2_data);
        end
        idle();
        cyc();
    endtask

    task automatic test_raw();
        issue(0, 0, 7, 1);
        cyc();
        issue(7, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (regfile_ready !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall cycle %0d: ready=%b expected 0", i, regfile_ready);
            end
            cyc();
        end
        wen = 1; waddr = 7; wdata = 32'hA5A5A5A5;
        #1;
        checks++;
        if (regfile_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_release_ready: got %b expected 1", regfile_ready);
        end
        cyc();
        checks++;
        if (regfile_valid !== 1'b1 || regfile_rs1_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL raw_release_data: valid=%b rs1=%h, expected 1/a5a5a5a5",
                     regfile_valid, regfile_rs1_data);
        end
        idle();
        cyc();
    endtask

    task automatic test_stall();
        issue(5, 7, 0, 0);
        cyc();
        execute_ready = 0;
        issue(7, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (regfile_ready !== 1'b0 || regfile_valid !== 1'b1 ||
                regfile_rs1_data !== 32'h12345678 || regfile_rs2_data !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: ready=%b valid=%b rs1=%h rs2=%h, expected 0/1/12345678/a5a5a5a5",
                         i, regfile_ready, regfile_valid, regfile_rs1_data, regfile_rs2_data);
            end
            cyc();
        end
        execute_ready = 1;
        #1;
        checks++;
        if (regfile_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 1", regfile_ready);
        end
        cyc();
        checks++;
        if (regfile_valid !== 1'b1 || regfile_rs1_data !== 32'hA5A5A5A5 || regfile_rs2_data !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_first: valid=%b rs1=%h rs2=%h, expected 1/a5a5a5a5/12345678",
                     regfile_valid, regfile_rs1_data, regfile_rs2_data);
        end
        issue(5, 5, 0, 0);
        cyc();
        checks++;
        if (regfile_valid !== 1'b1 || regfile_rs1_data !== 32'h12345678 || regfile_rs2_data !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_second: valid=%b rs1=%h rs2=%h, expected 1/12345678/12345678",
                     regfile_valid, regfile_rs1_data, regfile_rs2_data);
        end
        idle();
        cyc();
    endtask

    task automatic test_set_wins();
        issue(0, 0, 9, 1);
        wen = 1; waddr = 9; wdata = 32'h11111111;
        cyc();
        wen = 0;
        issue(9, 0, 0, 0);
        #1;
        checks++;
        if (regfile_ready !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_raw: ready=%b expected 0", regfile_ready);
        end
        issue(0, 0, 9, 1);
        #1;
        checks++;
        if (regfile_ready !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_waw: ready=%b expected 0", regfile_ready);
        end
        issue(9, 0, 0, 0);
        cyc();
        wen = 1; waddr = 9; wdata = 32'h22222222;
        cyc();
        checks++;
        if (regfile_valid !== 1'b1 || regfile_rs1_data !== 32'h22222222) begin
            errors++;
            $display("FAIL set_wins_release: valid=%b rs1=%h, expected 1/22222222",
                     regfile_valid, regfile_rs1_data);
        end
        idle();
        cyc();
    endtask

    task automatic test_flush();
        issue(0, 0, 3, 1);
        cyc();
        issue(0, 0, 4, 1);
        cyc();
        decoder_valid = 0;
        flush = 1;
        wen = 1; waddr = 3; wdata = 32'h33333333;
        #1;
        checks++;
        if (regfile_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 0", regfile_ready);
        end
        cyc();
        checks++;
        if (regfile_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b expected 0", regfile_valid);
        end
        flush = 0; wen = 0;
        issue(3, 4, 0, 0);
        #1;
        checks++;
        if (regfile_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_cleared: ready=%b expected 1", regfile_ready);
        end
        cyc();
        checks++;
        if (regfile_valid !== 1'b1 || regfile_rs1_data !== 32'h33333333 || regfile_rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL flush_write_commit: valid=%b rs1=%h rs2=%h, expected 1/33333333/00000000",
                     regfile_valid, regfile_rs1_data, regfile_rs2_data);
        end
        idle();
        cyc();
    endtask

    task automatic test_reset_mid_stall();
        issue(5, 9, 0, 0);
        cyc();
        decoder_valid = 0;
        execute_ready = 0;
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        #1;
        checks++;
        if (regfile_valid !== 1'b0 || regfile_rs1_data !== 32'h0 || regfile_rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_stall: valid=%b rs1=%h rs2=%h, expected 0/0/0",
                     regfile_valid, regfile_rs1_data, regfile_rs2_data);
        end
        execute_ready = 1;
        issue(5, 9, 0, 0);
        cyc();
        checks++;
        if (regfile_rs1_data !== 32'h0 || regfile_rs2_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_storage: rs1=%h rs2=%h, expected 00000000/00000000",
                     regfile_rs1_data, regfile_rs2_data);
        end
        idle();
        cyc();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_raw();
        test_stall();
        test_set_wins();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
